// File: rtl/boot_mem_ctrl.sv
// boot_mem_ctrl: boot memory with a ROM image, a scratch region zeroed by a
// reset-time clear sequencer, registered reads and write-error reporting.
//
// Ports:
//   clk      in  system clock, all flops on posedge
//   rst      in  asynchronous active-high reset
//   cs       in  bus select
//   we       in  1 = write, 0 = read (qualified by cs)
//   addr     in  word address (ADDR_W bits)
//   din      in  write data (DATA_W bits)
//   dout     out registered read data, holds last read value
//   dout_vld out one-cycle pulse, dout updated this cycle
//   busy     out clear sequencer running, bus accesses ignored
//   wr_err   out one-cycle pulse, rejected write
//
// Optional feature macro: BOOT_MEM_ROM_PATCH_EN
//   Makes ROM words writable until a sticky lock bit is set by any accepted
//   write to address DEPTH-1. Without it the ROM region is read-only.

module boot_mem_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int ROM_WORDS = 8,
    parameter logic [DATA_W*ROM_WORDS-1:0] ROM_IMAGE =
        128'h0000_4000_3008_F400_1007_F800_4000_F200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              busy,
    output logic              wr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_W-1:0]         r_clr_ptr;
    logic [DATA_W-1:0]         r_scr [ROM_WORDS:DEPTH-1];
    logic [DATA_W*ROM_WORDS-1:0] w_rom;
    logic [DATA_W-1:0]         w_rom_q;
    logic [DATA_W-1:0]         w_rdata;
    logic                      w_busy;
    logic                      w_clr_last;
    logic                      w_rom_hit;
    logic                      w_rd;
    logic                      w_wr;
    logic                      w_scr_wr;
    logic                      w_rom_wr;
    logic                      w_wr_err;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and sequencer controls
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_clr_last  = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                w_busy     = 1'b1;
                w_clr_last = (r_clr_ptr == ADDR_W'(DEPTH - 1));
                if (w_clr_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Clear pointer walks the scratch region once after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_ptr <= ADDR_W'(ROM_WORDS);
        end else if (w_busy) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // Bus decode: nothing is accepted while the sequencer runs
    assign w_rom_hit = (addr < ADDR_W'(ROM_WORDS));
    assign w_rd      = !w_busy && cs && !we;
    assign w_wr      = !w_busy && cs && we;
    assign w_scr_wr  = w_wr && !w_rom_hit;
    assign w_wr_err  = w_wr && w_rom_hit && !w_rom_wr;

`ifdef BOOT_MEM_ROM_PATCH_EN
    logic                        r_lock;
    logic [DATA_W*ROM_WORDS-1:0] r_rom;

    assign w_rom_wr = w_wr && w_rom_hit && !r_lock;

    // Patchable ROM, reloaded from the image on every reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom  <= ROM_IMAGE;
            r_lock <= 1'b0;
        end else begin
            if (w_rom_wr) begin
                r_rom[int'(addr)*DATA_W +: DATA_W] <= din;
            end
            // Lock is sticky until reset; the lock write still stores din
            if (w_scr_wr && (addr == ADDR_W'(DEPTH - 1))) begin
                r_lock <= 1'b1;
            end
        end
    end

    assign w_rom = r_rom;
`else
    assign w_rom_wr = 1'b0;
    assign w_rom    = ROM_IMAGE;
`endif

    // Scratch storage is not reset; the sequencer zeroes it instead
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_scr[r_clr_ptr] <= '0;
        end else if (w_scr_wr) begin
            r_scr[addr] <= din;
        end
    end

    assign w_rom_q = w_rom[int'(addr)*DATA_W +: DATA_W];
    assign w_rdata = w_rom_hit ? w_rom_q : r_scr[addr];

    // Registered read data and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            dout_vld <= w_rd;
            wr_err   <= w_wr_err;
            if (w_rd) begin
                dout <= w_rdata;
            end
        end
    end

    assign busy = w_busy;

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// tb_boot_mem_ctrl: directed and random checks of boot_mem_ctrl against
// an array-based reference model of the memory map.

module tb_boot_mem_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int RW    = 8;
    localparam int DEPTH = 16;
    localparam logic [127:0] IMG =
        128'h0000_4000_3008_F400_1007_F800_4000_F200;

`ifdef BOOT_MEM_ROM_PATCH_EN
    localparam bit PATCH = 1'b1;
`else
    localparam bit PATCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs  = 1'b0;
    logic          we  = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din  = '0;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          busy;
    logic          wr_err;

    always #5 clk = ~clk;

    boot_mem_ctrl #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .ROM_WORDS (RW),
        .ROM_IMAGE (IMG)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .wr_err   (wr_err)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_lock;
    logic [DW-1:0] m_dout;
    int            clr_left;
    logic [127:0]  img_v;
    logic [DW-1:0] tbl [RW];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        img_v = IMG;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = (i < RW) ? img_v[i*DW +: DW] : '0;
        end
        m_lock   = 1'b0;
        m_dout   = '0;
        clr_left = DEPTH - RW;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        cs  = 1'b0;
        we  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_vld", dout_vld, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_op(input bit c, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bit idle;
        bit e_vld;
        bit e_err;
        idle = (clr_left == 0);
        chk("busy", busy, !idle);
        cs    = c;
        we    = w;
        addr  = a;
        din   = d;
        e_vld = idle && c && !w;
        e_err = idle && c && w && (a < RW) && !(PATCH && !m_lock);
        if (e_vld) m_dout = m_mem[a];
        if (idle && c && w && !e_err) begin
            m_mem[a] = d;
            if (a == AW'(DEPTH - 1)) m_lock = 1'b1;
        end
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
        chk($sformatf("vld@%0h", a), dout_vld, e_vld);
        chk($sformatf("err@%0h", a), wr_err, e_err);
        chk($sformatf("dout@%0h", a), dout, m_dout);
        if (clr_left > 0) clr_left--;
    endtask

    initial begin
        int cnt;
        tbl[0] = 16'hF200; tbl[1] = 16'h4000;
        tbl[2] = 16'hF800; tbl[3] = 16'h1007;
        tbl[4] = 16'hF400; tbl[5] = 16'h3008;
        tbl[6] = 16'h4000; tbl[7] = 16'h0000;

        do_rst();
        // bus traffic during CLEAR must be ignored
        do_op(0, 0, 0, 0);
        do_op(1, 0, 0, 0);
        do_op(1, 1, 2, 16'h1111);
        do_op(1, 1, 15, 16'h0001);
        do_op(0, 0, 0, 0);
        do_op(0, 0, 0, 0);
        do_op(1, 1, 12, 16'hFFFF);
        do_op(1, 1, 12, 16'hFFFF);
        chk("busy_done", busy, 0);

        for (int i = 0; i < DEPTH; i++) begin
            do_op(1, 0, AW'(i), 0);
            chk($sformatf("img%0h", i), dout, (i < RW) ? tbl[i] : 16'h0);
        end

        do_op(1, 1, 9, 16'hA5A5);
        do_op(1, 0, 9, 0);
        chk("rd9", dout, 16'hA5A5);
        do_op(1, 0, 3, 0);
        do_op(0, 0, 0, 0);
        chk("hold3", dout, 16'h1007);

        do_op(1, 1, 2, 16'h1234);
        do_op(1, 0, 2, 0);
        chk("patch2", dout, PATCH ? 16'h1234 : 16'hF800);
        do_op(1, 1, 15, 16'h0001);
        do_op(1, 1, 2, 16'h5678);
        chk("lock_err", wr_err, 1);
        do_op(1, 0, 2, 0);
        chk("lock2", dout, PATCH ? 16'h1234 : 16'hF800);

        do_rst();
        repeat (4) do_op(0, 0, 0, 0);
        do_rst();
        cnt = 0;
        while (busy && cnt < 20) begin
            do_op(1, 1, 12, 16'hBEEF);
            cnt++;
        end
        chk("clr_len", cnt, 8);
        do_op(1, 0, 12, 0);
        chk("rdC", dout, 16'h0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 149) == 0) do_rst();
            do_op($urandom_range(0, 3) != 0, 1'($urandom),
                  AW'($urandom), DW'($urandom));
        end

        do_rst();
        repeat (8) do_op(0, 0, 0, 0);
        do_op(1, 1, 2, 16'h4321);
        do_rst();
        repeat (8) do_op(0, 0, 0, 0);
        do_op(1, 0, 2, 0);
        chk("rst_img2", dout, 16'hF800);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
